// File: rtl/egd_pkg.sv
// Shared constants for the Exp-Golomb bit aligner.
// Optional build macro: EGD_EPB_STRIP_EN (emulation-prevention byte removal).
package egd_pkg;

    // Default geometry of the bit buffer and the decoder look-ahead window.
    localparam int EGD_BUF_W = 32;
    localparam int EGD_WIN_W = 16;
    localparam int EGD_CNT_W = 32;

    // Emulation-prevention byte that follows two zero bytes in the stream.
    localparam logic [7:0] EPB_BYTE = 8'h03;

    // Bit positions inside err_o.
    localparam int ERR_OVERCONSUME = 0;
    localparam int ERR_COLLISION   = 1;

endpackage

// File: rtl/egd_bit_shifter.sv
// Combinational datapath of the aligner: left-shifts the MSB-aligned bit
// buffer by the number of bits leaving it, then ORs a new byte in at the
// first free bit position. Bits below the fill level are always zero, so an
// OR merge is sufficient.
module egd_bit_shifter
    import egd_pkg::*;
#(
    parameter int BUF_W = EGD_BUF_W,
    parameter int OFF_W = 6
) (
    input  logic [BUF_W-1:0] data_i,
    input  logic [4:0]       shamt_i,
    input  logic             ins_en_i,
    input  logic [OFF_W-1:0] ins_off_i,
    input  logic [7:0]       ins_byte_i,
    output logic [BUF_W-1:0] data_o
);

    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] merged;

    // Shift out consumed bits and place the incoming byte at the fill offset.
    always_comb begin
        shifted = data_i << shamt_i;
        merged  = {ins_byte_i, {(BUF_W-8){1'b0}}} >> ins_off_i;
        data_o  = ins_en_i ? (shifted | merged) : shifted;
    end

endmodule

// File: rtl/egd_bit_aligner.sv
// Byte-to-bit aligner feeding the Exp-Golomb decoder. Holds the slice byte
// stream in an MSB-aligned bit buffer, shows a look-ahead window, and drops
// bits as the decoder consumes them or requests byte alignment.
// Optional build macro: EGD_EPB_STRIP_EN strips 0x03 after two 0x00 bytes.
//
// Byte handshake: a byte transfers on a rising edge where in_valid_i and
// in_ready_o are both high. in_ready_o comes from registered fill state only,
// so it never depends combinationally on in_valid_i or the consume inputs.
module egd_bit_aligner
    import egd_pkg::*;
#(
    parameter int BUF_W = EGD_BUF_W,
    parameter int WIN_W = EGD_WIN_W,
    parameter int CNT_W = EGD_CNT_W
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [7:0]       in_data_i,
    output logic             in_ready_o,
    output logic [WIN_W-1:0] win_data_o,
    output logic [4:0]       win_avail_o,
    input  logic             cons_valid_i,
    input  logic [4:0]       cons_len_i,
    input  logic             align_i,
    output logic [2:0]       bit_pos_o,
    output logic [CNT_W-1:0] bits_used_o,
    output logic [1:0]       err_o
);

    localparam int FILL_W = $clog2(BUF_W + 1);

    logic [BUF_W-1:0]  data_q, data_d, data_next;
    logic [FILL_W-1:0] fill_q, fill_d, fill_mid;
    logic [2:0]        pos_q, pos_d;
    logic [CNT_W-1:0]  used_q, used_d;
    logic [1:0]        err_q, err_d;

    logic [4:0]        avail;
    logic [4:0]        shamt;
    logic [2:0]        align_drop;
    logic              accept;
    logic              ins_en;

    assign accept = in_valid_i && in_ready_o;

`ifdef EGD_EPB_STRIP_EN
    logic [1:0] zr_q, zr_d;
    logic       epb_drop;

    // Track consecutive zero bytes and swallow an 0x03 that follows two.
    always_comb begin
        epb_drop = accept && (zr_q == 2'd2) && (in_data_i == EPB_BYTE);
        zr_d     = zr_q;
        if (flush_i) begin
            zr_d = 2'd0;
        end else if (accept) begin
            if (epb_drop || (in_data_i != 8'h00)) begin
                zr_d = 2'd0;
            end else if (zr_q != 2'd2) begin
                zr_d = zr_q + 2'd1;
            end
        end
    end

    // Zero-run register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            zr_q <= 2'd0;
        end else begin
            zr_q <= zr_d;
        end
    end

    assign ins_en = accept && !epb_drop;
`else
    assign ins_en = accept;
`endif

    // Window is the top WIN_W buffer bits; availability saturates at WIN_W.
    always_comb begin
        win_data_o  = data_q[BUF_W-1 -: WIN_W];
        win_avail_o = (fill_q >= FILL_W'(WIN_W)) ? 5'(WIN_W) : fill_q[4:0];
        avail       = win_avail_o;
        in_ready_o  = (fill_q <= FILL_W'(BUF_W - 8));
        bit_pos_o   = pos_q;
        bits_used_o = used_q;
        err_o       = err_q;
    end

    // Decide how many bits leave the buffer: a consume beats an align.
    always_comb begin
        shamt      = 5'd0;
        err_d      = err_q;
        align_drop = 3'd0 - pos_q;
        if (cons_valid_i) begin
            if ((cons_len_i != 5'd0) && (cons_len_i <= avail)) begin
                shamt = cons_len_i;
            end else begin
                err_d[ERR_OVERCONSUME] = 1'b1;
            end
            if (align_i) begin
                err_d[ERR_COLLISION] = 1'b1;
            end
        end else if (align_i && (align_drop != 3'd0)) begin
            if (FILL_W'(align_drop) <= fill_q) begin
                shamt = {2'b00, align_drop};
            end else begin
                err_d[ERR_OVERCONSUME] = 1'b1;
            end
        end
    end

    assign fill_mid = fill_q - FILL_W'(shamt);

    egd_bit_shifter #(
        .BUF_W (BUF_W),
        .OFF_W (FILL_W)
    ) u_shifter (
        .data_i     (data_q),
        .shamt_i    (shamt),
        .ins_en_i   (ins_en),
        .ins_off_i  (fill_mid),
        .ins_byte_i (in_data_i),
        .data_o     (data_next)
    );

    // Next-state for buffer and counters; flush clears everything.
    always_comb begin
        data_d = data_next;
        fill_d = fill_mid + (ins_en ? FILL_W'(8) : FILL_W'(0));
        pos_d  = pos_q + shamt[2:0];
        used_d = used_q + CNT_W'(shamt);
        if (flush_i) begin
            data_d = '0;
            fill_d = '0;
            pos_d  = 3'd0;
            used_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            data_q <= '0;
            fill_q <= '0;
            pos_q  <= 3'd0;
            used_q <= '0;
            err_q  <= 2'b00;
        end else begin
            data_q <= data_d;
            fill_q <= fill_d;
            pos_q  <= pos_d;
            used_q <= used_d;
            err_q  <= flush_i ? 2'b00 : err_d;
        end
    end

endmodule

// File: tb/tb_egd_bit_aligner.sv
// Directed bench for egd_bit_aligner. Expected values are hand-computed.
// Honours EGD_EPB_STRIP_EN when choosing expectations for the EPB scenario.
module tb_egd_bit_aligner;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] win_data;
    logic [4:0]  win_avail;
    logic        cons_valid;
    logic [4:0]  cons_len;
    logic        align;
    logic [2:0]  bit_pos;
    logic [31:0] bits_used;
    logic [1:0]  err;

    int total;
    int bad;

    egd_bit_aligner dut (
        .wb_clk_i     (clk),
        .wb_rst_n     (rst_n),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .win_data_o   (win_data),
        .win_avail_o  (win_avail),
        .cons_valid_i (cons_valid),
        .cons_len_i   (cons_len),
        .align_i      (align),
        .bit_pos_o    (bit_pos),
        .bits_used_o  (bits_used),
        .err_o        (err)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs, then inputs return to idle.
    task automatic cyc(input logic cv, input logic [4:0] len, input logic al,
                       input logic iv, input logic [7:0] d, input logic fl);
        cons_valid = cv;
        cons_len   = len;
        align      = al;
        in_valid   = iv;
        in_data    = d;
        flush      = fl;
        @(posedge clk);
        #1;
        cons_valid = 1'b0;
        cons_len   = 5'd0;
        align      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        flush      = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b0, 5'd0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic consume(input logic [4:0] len);
        cyc(1'b1, len, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_flush();
        cyc(1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        cons_valid = 1'b0;
        cons_len   = 5'd0;
        align      = 1'b0;

        // Reset.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_win", 32'(win_data), 32'h0);
        chk("rst_avail", 32'(win_avail), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_used", bits_used, 32'd0);
        chk("rst_pos", 32'(bit_pos), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Two bytes, no consume.
        push(8'hA5);
        push(8'h3C);
        chk("push2_win", 32'(win_data), 32'hA53C);
        chk("push2_avail", 32'(win_avail), 32'd16);
        chk("push2_ready", 32'(in_ready), 32'd1);

        // Consume 3 bits.
        consume(5'd3);
        chk("c3_win", 32'(win_data), 32'h29E0);
        chk("c3_avail", 32'(win_avail), 32'd13);
        chk("c3_pos", 32'(bit_pos), 32'd3);
        chk("c3_used", bits_used, 32'd3);

        // Align drops 5 bits.
        cyc(1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("al_win", 32'(win_data), 32'h3C00);
        chk("al_avail", 32'(win_avail), 32'd8);
        chk("al_pos", 32'(bit_pos), 32'd0);
        chk("al_used", bits_used, 32'd8);

        // Align when already aligned is a no-op.
        cyc(1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("al0_win", 32'(win_data), 32'h3C00);
        chk("al0_used", bits_used, 32'd8);
        chk("al0_err", 32'(err), 32'd0);

        // Flush with a byte offered: byte discarded.
        cyc(1'b0, 5'd0, 1'b0, 1'b1, 8'h77, 1'b1);
        chk("fl_avail", 32'(win_avail), 32'd0);
        chk("fl_win", 32'(win_data), 32'h0);
        chk("fl_used", bits_used, 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);

        // Fill to 32 bits.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        chk("full_win", 32'(win_data), 32'h1122);
        chk("full_avail", 32'(win_avail), 32'd16);
        chk("full_ready", 32'(in_ready), 32'd0);

        // Consume 8 while a byte is offered but ready is low.
        cyc(1'b1, 5'd8, 1'b0, 1'b1, 8'h55, 1'b0);
        chk("bp_win", 32'(win_data), 32'h2233);
        chk("bp_ready", 32'(in_ready), 32'd1);
        chk("bp_used", bits_used, 32'd8);

        // Drain 16: only 0x44 remains, proving 0x55 was never inserted.
        consume(5'd16);
        chk("dr_win", 32'(win_data), 32'h4400);
        chk("dr_avail", 32'(win_avail), 32'd8);
        chk("dr_used", bits_used, 32'd24);

        // Over-consume.
        consume(5'd9);
        chk("oc_err", 32'(err), 32'd1);
        chk("oc_win", 32'(win_data), 32'h4400);
        chk("oc_avail", 32'(win_avail), 32'd8);
        chk("oc_used", bits_used, 32'd24);

        // Align + consume collision: consume applies.
        cyc(1'b1, 5'd1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("col_err", 32'(err), 32'd3);
        chk("col_win", 32'(win_data), 32'h8800);
        chk("col_avail", 32'(win_avail), 32'd7);
        chk("col_pos", 32'(bit_pos), 32'd1);
        chk("col_used", bits_used, 32'd25);

        // Flush clears errors and buffer.
        do_flush();
        chk("fl2_err", 32'(err), 32'd0);
        chk("fl2_avail", 32'(win_avail), 32'd0);
        chk("fl2_pos", 32'(bit_pos), 32'd0);

        // Zero length is illegal.
        push(8'hA5);
        push(8'h3C);
        consume(5'd0);
        chk("z_err", 32'(err), 32'd1);
        chk("z_avail", 32'(win_avail), 32'd16);
        chk("z_used", bits_used, 32'd0);
        do_flush();

        // Consume and insert in the same cycle.
        push(8'hA5);
        push(8'h3C);
        cyc(1'b1, 5'd4, 1'b0, 1'b1, 8'hF0, 1'b0);
        chk("ci_win", 32'(win_data), 32'h53CF);
        chk("ci_avail", 32'(win_avail), 32'd16);
        chk("ci_used", bits_used, 32'd4);
        chk("ci_ready", 32'(in_ready), 32'd1);
        do_flush();

        // Emulation-prevention sequence 00 00 03 01.
        push(8'h00);
        push(8'h00);
        push(8'h03);
        push(8'h01);
        chk("epb_win", 32'(win_data), 32'h0000);
        chk("epb_avail", 32'(win_avail), 32'd16);
`ifdef EGD_EPB_STRIP_EN
        chk("epb_ready", 32'(in_ready), 32'd1);
        consume(5'd16);
        chk("epb_tail_win", 32'(win_data), 32'h0100);
        chk("epb_tail_avail", 32'(win_avail), 32'd8);
`else
        chk("epb_ready", 32'(in_ready), 32'd0);
        consume(5'd16);
        chk("epb_tail_win", 32'(win_data), 32'h0301);
        chk("epb_tail_avail", 32'(win_avail), 32'd16);
`endif
        do_flush();

        // Asynchronous reset mid-stream.
        push(8'hA5);
        push(8'h3C);
        consume(5'd3);
        consume(5'd20);
        chk("pre_avail", 32'(win_avail), 32'd13);
        chk("pre_err", 32'(err), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_win", 32'(win_data), 32'h0);
        chk("arst_avail", 32'(win_avail), 32'd0);
        chk("arst_used", bits_used, 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_ready", 32'(in_ready), 32'd1);
        push(8'h5A);
        chk("post_win", 32'(win_data), 32'h5A00);
        chk("post_avail", 32'(win_avail), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/egd_bit_aligner.md
Name: egd_bit_aligner

Overview:
Upstream feeder for the Exp-Golomb decoder (egd_top_wrapper). Accepts the H.264 slice byte stream over a valid/ready byte interface and holds it in a 32-bit MSB-aligned bit buffer. Presents a 16-bit look-ahead window to the decoder. The decoder reports how many bits it used each cycle, and the buffer shifts by that amount. Also provides a byte-align operation for rbsp_trailing_bits and slice-header alignment.

Parameters:
BUF_W, 32, bit-buffer width; must be a multiple of 8 and at least WIN_W+8.
WIN_W, 16, look-ahead window width presented to the decoder.
CNT_W, 32, width of the total-bits-consumed counter.

Ports:
wb_clk_i  input  1  single clock
wb_rst_n  input  1  asynchronous active-low reset
flush_i  input  1  synchronous clear of buffer, counters and error flags
in_valid_i  input  1  byte valid
in_data_i  input  8  stream byte, MSB first
in_ready_o  output  1  byte accepted when in_valid_i && in_ready_o
win_data_o  output  WIN_W  buf[BUF_W-1 -: WIN_W]; bits at or below fill level read 0
win_avail_o  output  5  min(fill_cnt, WIN_W)
cons_valid_i  input  1  consume request
cons_len_i  input  5  bits to consume, 1..WIN_W
align_i  input  1  discard bits up to the next byte boundary
bit_pos_o  output  3  total consumed bits mod 8
bits_used_o  output  CNT_W  total bits consumed, wraps modulo 2^CNT_W
err_o  output  2  sticky: [0] over-consume or illegal length, [1] align/consume collision

Behaviour:
- Reset (async assert, sync release): buf=0, fill_cnt=0, bit_pos=0, bits_used=0, err=0. Outputs after reset: win_data_o=0, win_avail_o=0, in_ready_o=1.
- in_ready_o = (fill_cnt <= BUF_W-8). It depends on registered state only; there is no combinational path from cons_* to in_ready_o.
- Per-cycle update, strict priority:
  1. flush_i: behaves like reset and overrides all other inputs this cycle; a byte offered this cycle is accepted but discarded.
  2. Consume: legal if 1 <= cons_len_i <= win_avail_o. Then buf <<= cons_len_i, fill_cnt -= cons_len_i, bit_pos += cons_len_i (mod 8), bits_used += cons_len_i. If illegal: no state change and err[0] set.
  3. Align, only when cons_valid_i=0: drop (8-bit_pos)%8 bits, same arithmetic as a consume. bit_pos=0 is a no-op. If fewer bits are buffered than need dropping: no state change and err[0] set. If align_i and cons_valid_i are both high, the consume executes, the align is dropped and err[1] is set.
  4. Byte insert: the accepted byte is written at bit offset (fill_cnt after step 2/3), counted from the MSB. fill_cnt += 8.
- Consume and insert in the same cycle are both applied. Net fill = fill - len + 8, which never exceeds BUF_W because insert requires fill <= BUF_W-8.
- Latency: an inserted or consumed bit changes win_data_o and win_avail_o on the next rising edge (1 cycle).
- The decoder may use win_data_o only when win_avail_o >= the bits it needs.
- bits_used_o wraps silently.
- err_o clears only on reset or flush_i.

Optional Feature:
EGD_EPB_STRIP_EN
- Defined: emulation-prevention removal. A zero-run counter zr (0..2) tracks consecutive inserted 0x00 bytes. An accepted 0x03 byte with zr==2 is consumed from the handshake but not inserted, and zr is reset to 0. A non-zero inserted byte also resets zr. flush_i and reset clear zr.
- Undefined: every accepted byte is inserted; no zr logic is present.

Decomposition:
- egd_pkg holds: BUF_W/WIN_W defaults, EPB byte constant 8'h03, and localparams ERR_OVERCONSUME=0 and ERR_COLLISION=1.
- One natural sub-module, egd_bit_shifter: combinational left barrel shift by 0..WIN_W plus byte merge at a variable offset. The top level keeps the counters, priority logic and handshake.

Test Plan:
- Push 0xA5, 0x3C with no consume -> win_data_o=0xA53C, win_avail_o=16, in_ready_o=1.
- From 0xA53C: consume 3 -> win_data_o=0x29E0, win_avail_o=13, bit_pos_o=3, bits_used_o=3. Then align_i -> win_data_o=0x3C00, win_avail_o=8, bit_pos_o=0, bits_used_o=8.
- Push 4 bytes with no consume -> fill 32, in_ready_o=0. Next cycle consume 8 with a byte offered -> byte not accepted (ready was 0). Cycle after that: in_ready_o=1.
- win_avail_o=8, consume 9 -> no state change, err_o=2'b01. Then assert align_i and consume 1 together -> consume applied, err_o=2'b11. Then flush_i -> err_o=0, win_avail_o=0.
- With EGD_EPB_STRIP_EN, bytes 00 00 03 01 -> win_data_o=0x0000, win_avail_o=16 (24 bits buffered: 00 00 01). Without the macro -> 32 bits buffered, 0x00000301.
- Deassert wb_rst_n mid-stream with win_avail_o=13 -> win_data_o, win_avail_o, bits_used_o and err_o are all 0 immediately. After release, in_ready_o=1 and a new byte is accepted normally.
